// File: rtl/spi_ram_slave_burst.sv
// SPI slave with an integrated single-port RAM: 2-bit command frames plus
// optional address-auto-increment bursts for write-data and read-data.
module spi_ram_slave_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter bit BURST_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] CMD_WADDR = 2'b00;
  localparam logic [1:0] CMD_WDATA = 2'b01;
  localparam logic [1:0] CMD_RADDR = 2'b10;
  localparam logic [1:0] CMD_RDATA = 2'b11;

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_e;
  // Work deferred to the edge after a word completes; it runs even if SS_n rises.
  typedef enum logic [2:0] {ACT_NONE, ACT_WADDR, ACT_WDATA, ACT_RADDR, ACT_RDATA} act_e;

  state_e                state_q, state_d;
  act_e                  act_q, act_d;
  logic [1:0]            cmd_q, cmd_d;
  logic                  hdr_q, hdr_d;
  logic                  done_q, done_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  miso_q, miso_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rx_next;

  assign rd_word = mem[rd_addr_q];
  assign MISO    = miso_q;

  // NOTE: every always_comb output gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    act_d     = ACT_NONE;
    cmd_d     = cmd_q;
    hdr_d     = hdr_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    word_d    = word_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    rd_pend_d = rd_pend_q;
    rx_next   = DATA_WIDTH'({rx_q, MOSI});
    // Shifting zeros in behind the data returns MISO to 0 after the last bit.
    miso_d    = tx_q[DATA_WIDTH-1];
    tx_d      = tx_q << 1;

    case (act_q)
      ACT_WADDR: wr_addr_d = word_q[ADDR_WIDTH-1:0];
      ACT_WDATA: wr_addr_d = wr_addr_q + 1'b1;
      ACT_RADDR: begin
        rd_addr_d = word_q[ADDR_WIDTH-1:0];
        rd_pend_d = 1'b1;
      end
      ACT_RDATA: begin
        if (!SS_n) begin
          miso_d    = rd_word[DATA_WIDTH-1];
          tx_d      = rd_word << 1;
          rd_addr_d = rd_addr_q + 1'b1;
          rd_pend_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (SS_n) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      tx_d    = '0;
      rx_d    = '0;
      cnt_d   = '0;
      hdr_d   = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CHK_CMD;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
        CHK_CMD: begin
          cmd_d[1] = MOSI;
          hdr_d    = 1'b1;
          cnt_d    = '0;
          if (!MOSI)         state_d = WRITE;
          else if (rd_pend_q) state_d = READ_DATA;
          else               state_d = READ_ADD;
        end
        WRITE, READ_ADD, READ_DATA: begin
          if (hdr_q) begin
            cmd_d[0] = MOSI;
            hdr_d    = 1'b0;
          end else if (!done_q) begin
            rx_d = rx_next;
            if (cnt_q == LAST_BIT) begin
              cnt_d  = '0;
              word_d = rx_next;
              case (cmd_q)
                CMD_WADDR: begin act_d = ACT_WADDR; done_d = 1'b1;      end
                CMD_WDATA: begin act_d = ACT_WDATA; done_d = !BURST_EN; end
                CMD_RADDR: begin act_d = ACT_RADDR; done_d = 1'b1;      end
                default:   begin act_d = ACT_RDATA; done_d = !BURST_EN; end
              endcase
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      act_q     <= ACT_NONE;
      cmd_q     <= '0;
      hdr_q     <= 1'b0;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      rx_q      <= '0;
      word_q    <= '0;
      tx_q      <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      act_q     <= act_d;
      cmd_q     <= cmd_d;
      hdr_q     <= hdr_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      word_q    <= word_d;
      tx_q      <= tx_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_pend_q <= rd_pend_d;
      miso_q    <= miso_d;
    end
  end

  // NOTE: the RAM array has no reset; contents survive rst_n and it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (act_q == ACT_WDATA) mem[wr_addr_q] <= word_q;
  end

endmodule

// File: tb/tb_spi_ram_slave_burst.sv
// Directed + randomized bench for spi_ram_slave_burst; a burst and a single-word
// instance are each checked against an edge-indexed MISO model per frame.
module tb_spi_ram_slave_burst;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ss1   = 1'b1, mosi1 = 1'b0, miso1;
  logic ss0   = 1'b1, mosi0 = 1'b0, miso0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rmem [2][DEPTH];
  int            m_wr [2];
  int            m_rd [2];
  bit            m_burst [2];
  logic [DW-1:0] wq [$];

  spi_ram_slave_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_EN(1'b1)) u_dut_burst (
    .clk(clk), .rst_n(rst_n), .SS_n(ss1), .MOSI(mosi1), .MISO(miso1)
  );

  spi_ram_slave_burst #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_EN(1'b0)) u_dut_single (
    .clk(clk), .rst_n(rst_n), .SS_n(ss0), .MOSI(mosi0), .MISO(miso0)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs at the falling edge, sample MISO at the next falling edge.
  task automatic tick(input int sel, input logic ss, input logic mosi, output logic m);
    if (sel == 1) begin ss1 = ss; mosi1 = mosi; end
    else          begin ss0 = ss; mosi0 = mosi; end
    @(posedge clk);
    @(negedge clk);
    m = (sel == 1) ? miso1 : miso0;
  endtask

  // Expected MISO after each edge Ei of a frame, plus the model state update.
  task automatic model(input int sel, input logic [1:0] cmd, input int nwords, input int extra,
                       output logic [127:0] exp);
    int p = nwords * DW + extra;
    int c = p / DW;
    int n;
    int l;
    int idx;
    logic [DW-1:0] w;
    exp = '0;
    case (cmd)
      2'b00: if (c >= 1 && nwords >= 1) begin w = wq[0]; m_wr[sel] = int'(w[AW-1:0]); end
      2'b10: if (c >= 1 && nwords >= 1) begin w = wq[0]; m_rd[sel] = int'(w[AW-1:0]); end
      2'b01: begin
        n = m_burst[sel] ? c : ((c >= 1) ? 1 : 0);
        if (n > nwords) n = nwords;
        for (int k = 0; k < n; k++) rmem[sel][(m_wr[sel] + k) % DEPTH] = wq[k];
        m_wr[sel] = (m_wr[sel] + n) % DEPTH;
      end
      default: begin
        l = (p >= 1) ? (p - 1) / DW : 0;
        if (!m_burst[sel] && l > 1) l = 1;
        for (int j = 0; j < l; j++) begin
          w = rmem[sel][(m_rd[sel] + j) % DEPTH];
          for (int b = 0; b < DW; b++) begin
            idx = DW + 3 + j * DW + b;
            if (idx <= 2 + p) exp[idx] = w[DW-1-b];
          end
        end
        m_rd[sel] = (m_rd[sel] + l) % DEPTH;
      end
    endcase
  endtask

  // One SS_n-low frame (E0, 2 cmd bits, payload words from wq, extra random bits),
  // followed by a single SS_n-high edge; the whole MISO trace is one comparison.
  task automatic do_frame(input int sel, input logic [1:0] cmd, input int nwords, input int extra,
                          input string tag);
    logic [127:0] obs;
    logic [127:0] exp;
    logic [DW-1:0] w;
    logic m;
    logic b;
    int p = nwords * DW + extra;
    obs = '0;
    tick(sel, 1'b0, 1'($urandom), m); obs[0] = m;
    tick(sel, 1'b0, cmd[1], m);       obs[1] = m;
    tick(sel, 1'b0, cmd[0], m);       obs[2] = m;
    for (int i = 0; i < p; i++) begin
      if (i < nwords * DW) begin
        w = wq[i / DW];
        b = w[DW-1-(i % DW)];
      end else begin
        b = 1'($urandom);
      end
      tick(sel, 1'b0, b, m);
      obs[3+i] = m;
    end
    tick(sel, 1'b1, 1'($urandom), m);
    obs[3+p] = m;
    model(sel, cmd, nwords, extra, exp);
    check(tag, obs, exp);
  endtask

  task automatic set_waddr(input int sel, input int a);
    wq = {DW'(a)};
    do_frame(sel, 2'b00, 1, 0, "wr_addr_frame");
  endtask

  task automatic set_raddr(input int sel, input int a);
    wq = {DW'(a)};
    do_frame(sel, 2'b10, 1, 0, "rd_addr_frame");
  endtask

  task automatic rd_words(input int sel, input int n, input string tag);
    wq = {};
    for (int i = 0; i <= n; i++) wq.push_back(DW'($urandom));
    do_frame(sel, 2'b11, n + 1, 0, tag);
  endtask

  initial begin
    logic m;
    logic [DW-1:0] w;
    int a;
    int n;

    m_burst[0] = 1'b0;
    m_burst[1] = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin rmem[0][i] = '0; rmem[1][i] = '0; end

    // Reset: MISO low throughout on both instances.
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_miso", {miso1, miso0}, 2'b00);
    end
    rst_n = 1'b1;
    m_wr[0] = 0; m_wr[1] = 0; m_rd[0] = 0; m_rd[1] = 0;

    // Test 1: write 0x3C at reset-time wr_addr 0, read without a prior read-address.
    wq = {8'h3C};
    do_frame(1, 2'b01, 1, 0, "t1_write_mem0");
    rd_words(1, 1, "t1_read_mem0");

    // Test 2: single transfers, fixed then random.
    set_waddr(1, 'h0F);
    wq = {8'hA5};
    do_frame(1, 2'b01, 1, 0, "t2_write_a5");
    set_raddr(1, 'h0F);
    rd_words(1, 1, "t2_read_a5");
    repeat (3) begin
      a = int'($urandom_range(255, 0));
      set_waddr(1, a);
      wq = {DW'($urandom)};
      do_frame(1, 2'b01, 1, 0, "t2_write_rand");
      set_raddr(1, a);
      rd_words(1, 1, "t2_read_rand");
    end

    // Test 3: write burst across the address wrap, then contiguous read burst.
    set_waddr(1, 'hFE);
    wq = {8'h11, 8'h22, 8'h33};
    do_frame(1, 2'b01, 3, 0, "t3_write_burst_wrap");
    set_raddr(1, 'hFE);
    rd_words(1, 3, "t3_read_burst_wrap");
    repeat (3) begin
      a = int'($urandom_range(255, 0));
      n = int'($urandom_range(4, 1));
      set_waddr(1, a);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(DW'($urandom));
      do_frame(1, 2'b01, n, 0, "t3_write_burst_rand");
      set_raddr(1, a);
      rd_words(1, n, "t3_read_burst_rand");
    end

    // Test 4: aborted write-data frame leaves RAM and wr_addr alone.
    set_waddr(1, 'h20);
    wq = {DW'($urandom)};
    do_frame(1, 2'b01, 1, 0, "t4_prefill");
    set_waddr(1, 'h20);
    do_frame(1, 2'b01, 0, 5, "t4_abort");
    set_raddr(1, 'h20);
    rd_words(1, 1, "t4_read_unchanged");
    wq = {8'h5A};
    do_frame(1, 2'b01, 1, 0, "t4_write_5a");
    set_raddr(1, 'h20);
    rd_words(1, 1, "t4_read_5a");

    // Test 5: reset during the third word of a 4-word write burst at 0x40.
    set_waddr(1, 'h40);
    wq = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
    do_frame(1, 2'b01, 4, 0, "t5_prefill");
    set_waddr(1, 'h40);
    wq = {DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom)};
    tick(1, 1'b0, 1'($urandom), m);
    tick(1, 1'b0, 1'b0, m);
    tick(1, 1'b0, 1'b1, m);
    for (int i = 0; i < 2 * DW + 3; i++) begin
      w = wq[i / DW];
      tick(1, 1'b0, w[DW-1-(i % DW)], m);
    end
    #2 rst_n = 1'b0;
    ss1 = 1'b1;
    #1 check("t5_reset_miso", {miso1, miso0}, 2'b00);
    rmem[1][64] = wq[0];
    rmem[1][65] = wq[1];
    m_wr[0] = 0; m_wr[1] = 0; m_rd[0] = 0; m_rd[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1, 1'b1, 1'b0, m);
    wq = {DW'($urandom)};
    do_frame(1, 2'b01, 1, 0, "t5_write_after_reset");
    rd_words(1, 1, "t5_read_addr_zero");
    set_raddr(1, 'h40);
    rd_words(1, 3, "t5_read_40_42");

    // Test 6: single-word instance ignores burst continuation for writes and reads.
    a = int'($urandom_range(200, 16));
    set_waddr(0, a + 2);
    wq = {DW'($urandom)};
    do_frame(0, 2'b01, 1, 0, "t6_prefill");
    set_waddr(0, a);
    wq = {DW'($urandom)};
    do_frame(0, 2'b01, 1, 0, "t6_write_x");
    wq = {DW'($urandom), DW'($urandom)};
    do_frame(0, 2'b01, 2, 0, "t6_write_no_burst");
    set_raddr(0, a);
    wq = {DW'($urandom)};
    do_frame(0, 2'b11, 1, 30, "t6_read_one_word");
    rd_words(0, 1, "t6_read_next");
    rd_words(0, 1, "t6_read_prefill_kept");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_ram_slave_burst.md
# spi_ram_slave_burst

Parametrised SPI slave with an integrated single-port RAM. It is the next generation of the team's fixed 8-bit SPI slave + RAM wrapper: word width and memory depth are configurable, and it adds address auto-increment burst transfers for write-data and read-data commands. The block sits between an external SPI master and on-chip storage and exposes only the SPI pins.

## Interface
- `DATA_WIDTH`, default 8: RAM word width; payload bits per frame and per burst word.
- `ADDR_WIDTH`, default 8: RAM address width. Memory depth is 2**ADDR_WIDTH. Legal range is 1..DATA_WIDTH.
- `BURST_EN`, default 1: 1 enables burst continuation; 0 gives single-word legacy behaviour.
- `clk`  in  1  Single clock for all logic; everything samples on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `SS_n`  in  1  Slave select, active low. High means idle or abort.
- `MOSI`  in  1  Serial data in, MSB first.
- `MISO`  out  1  Serial data out, MSB first. Drives 0 when not transmitting; no tristate.

## Operation
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE to CHK_CMD on the first edge with SS_n=0 (edge E0); MOSI is ignored at E0.
- At E1, CHK_CMD samples cmd[1]:
  - 0 goes to WRITE.
  - 1 goes to READ_ADD if no read address is pending, otherwise READ_DATA.
  - The pending flag is set by cmd 10 and cleared by cmd 11.
- Frame format: 2 command bits at E1–E2, then DATA_WIDTH payload bits at E3..E(DW+2), MSB first (DW = DATA_WIDTH).
- Command codes:
  - 00, write address: wr_addr <= payload[ADDR_WIDTH-1:0].
  - 01, write data: mem[wr_addr] <= payload, then wr_addr increments.
  - 10, read address: rd_addr <= payload[ADDR_WIDTH-1:0], pending flag set.
  - 11, read data: payload bits are don't-care. mem[rd_addr] is shifted out on MISO, then rd_addr increments.
- Burst (BURST_EN=1, SS_n held low after a complete 01 or 11 frame):
  - Each further DW edges form another word with no command bits.
  - Write burst: word k is written to wr_addr+k.
  - Read burst: streams mem[rd_addr+k] on MISO with no gap between words.
- Addresses wrap modulo 2**ADDR_WIDTH (all-ones increments to 0).
- Commands 00 and 10 never burst; extra bits are ignored until SS_n rises.
- BURST_EN=0: any bits after the first word are ignored for all commands.
- SS_n high at any edge: the next state is IDLE. A partial frame or partial burst word is discarded with no RAM write and no address change. Words already completed stay committed.
- RAM contents are not reset.

## Timing
- Reset values: MISO=0, state=IDLE, wr_addr=0, rd_addr=0, pending flag=0, shift registers=0.
- Reset asserted mid-operation: the above values apply immediately (asynchronously); RAM contents are retained.
- Write latency: the word whose last bit is sampled at edge En is committed to RAM at edge En+1. It is readable by any read frame that starts afterwards.
- Address update: wr_addr and rd_addr update at the edge after the last payload bit.
- Read-data frame, first word:
  - The RAM is read at E(DW+3).
  - MISO carries bit DW-1 after E(DW+3) and bit 0 after E(2DW+2).
- Read burst: word k bit DW-1 follows word k-1 bit 0 on the very next edge. The next word is fetched during the current word.
- Write burst: word k (k≥1) occupies E(DW+3+(k-1)DW)..E(DW+2+kDW).
- MISO returns to 0 on the edge after the last bit when not bursting, and on the edge SS_n is sampled high.
- A new frame may start immediately: SS_n high for one edge, then low.

## Test plan
Bench configuration is DW=8, ADDR_WIDTH=8 unless stated.
1. Reset, then a read-data frame with no prior read-address (mem[0] written to 0x3C beforehand) -> MISO=0 throughout reset; frame returns 0011_1100 at E11..E18.
2. Single transfers: write addr 0x0F, write data 0xA5, read addr 0x0F, read data -> MISO shows 1010_0101 at E11..E18, then 0.
3. Write burst: write addr 0xFE, then one SS_n-low frame with cmd 01 followed by 0x11, 0x22, 0x33 -> mem[FE]=0x11, mem[FF]=0x22, mem[00]=0x33 (wrap). Read addr 0xFE plus a read burst of 3 words -> 0x11, 0x22, 0x33 contiguous on MISO.
4. Abort: after write addr 0x20, a write-data frame with SS_n raised after 5 payload bits -> mem[0x20] unchanged, wr_addr=0x20. The following full frame writing 0x5A lands at 0x20.
5. Reset mid-burst: rst_n pulsed low during the third word of a 4-word write burst starting at 0x40 -> mem[0x40], mem[0x41] hold the new data; mem[0x42] is unchanged; MISO=0; wr_addr=0.
6. BURST_EN=0: a read-data frame with SS_n held low for 30 extra edges -> exactly one word on MISO, then 0; rd_addr is incremented once.
